mem_arbiter: RTL and testbench

//   Shares the single-port data RAM between two requesters: port 0 is the CPU data port,

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 33 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_DMA = 1;
  localparam int unsigned STAT_W   = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; the pointer remembers which port was granted last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] pick
);

  // 1 means port 1 was granted last, so port 0 wins the next tie
  logic last_q;

  // Single requester wins outright; a tie goes to the port not granted last
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_q ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  // Pointer moves only when a grant is actually taken
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (advance && (req != 2'b00)) begin
      last_q <= pick[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port data RAM between the CPU data port (0) and the DMA port (1).
// One access at a time: IDLE -> ISSUE -> (write: IDLE | read: WAIT -> RESP -> IDLE).
// Optional build macro MEM_ARB_STATS_EN enables the contention counter on stat_conflicts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_wr_sig,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [STAT_W-1:0] stat_conflicts
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e            state_q;
  logic              idx_q;
  logic              we_q;
  logic [CntW-1:0]   cnt_q;
  logic              gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, ram_wr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        pick;
  logic              in_idle;

  assign in_idle = (state_q == StIdle);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1, req0}),
    .advance (in_idle),
    .pick    (pick)
  );

  // Access sequencer; all outputs registered so they align with the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      ram_wr_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick != 2'b00) begin
            idx_q       <= pick[1];
            we_q        <= pick[1] ? we1 : we0;
            ram_addr_q  <= pick[1] ? addr1 : addr0;
            ram_wdata_q <= pick[1] ? wdata1 : wdata0;
            ram_wr_q    <= pick[1] ? we1 : we0;
            gnt0_q      <= pick[0];
            gnt1_q      <= pick[1];
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (we_q) begin
            state_q <= StIdle;
          end else begin
            cnt_q   <= CntW'(RD_LAT - 1);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            rdata_q   <= ram_rd_data;
            rvalid0_q <= (idx_q == 1'(PORT_CPU));
            rvalid1_q <= (idx_q == 1'(PORT_DMA));
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata0      = rdata_q;
  assign rdata1      = rdata_q;
  assign ram_wr_sig  = ram_wr_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wr_data = ram_wdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q;

  // Saturating count of IDLE cycles in which both ports were requesting
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
    end else if (in_idle && req0 && req1 && (stat_q != {STAT_W{1'b1}})) begin
      stat_q <= stat_q + STAT_W'(1);
    end
  end

  assign stat_conflicts = stat_q;
`else
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

  parameter int unsigned RD_LAT = 1;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_wr_sig;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
  logic [15:0]   stat_conflicts;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .req1           (req1),
    .we0            (we0),
    .we1            (we1),
    .addr0          (addr0),
    .addr1          (addr1),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .rvalid0        (rvalid0),
    .rvalid1        (rvalid1),
    .rdata0         (rdata0),
    .rdata1         (rdata1),
    .ram_wr_sig     (ram_wr_sig),
    .ram_addr       (ram_addr),
    .ram_wr_data    (ram_wr_data),
    .ram_rd_data    (ram_rd_data),
    .stat_conflicts (stat_conflicts)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: 16 words, writes commit at the edge, reads delayed by RD_LAT edges
  logic [DW-1:0] ram_mem [16] = '{default: '0};
  logic [DW-1:0] pipe [RD_LAT] = '{default: '0};

  always @(posedge clk) begin
    if (ram_wr_sig === 1'b1) ram_mem[ram_addr[5:2]] <= ram_wr_data;
    pipe[0] <= ram_mem[ram_addr[5:2]];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign ram_rd_data = pipe[RD_LAT-1];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    int            cyc;
    int            port;
    logic [DW-1:0] data;
  } rsp_t;

  int   n_checks, n_errors;
  int   cyc, free_at, last, stat_model, hold_from, hold_to;
  bit   model_valid, rst_drive, rst_prev;
  bit   busy0, busy1, done0, done1;
  logic [1:0]    req_prev;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] golden [16];
  cmd_t cur0, cur1;
  cmd_t q0[$], q1[$];
  rsp_t rvq[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic cmd_t make_cmd(input logic we, input logic [AW-1:0] addr,
                                    input logic [DW-1:0] data);
    cmd_t c;
    c.we   = we;
    c.addr = addr;
    c.data = data;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return make_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)) << 2, DW'($urandom));
  endfunction

  // One clock cycle: drive after the edge, then check the model on the falling edge
  task automatic step();
    cmd_t  c;
    logic [1:0] exp_gnt;
    bit    exp_any;
    int    port;
    @(posedge clk);
    cyc++;
    #1;
    reset = rst_drive;
    if (rst_drive) begin
      req0 = 1'b0; req1 = 1'b0;
      busy0 = 0; busy1 = 0; done0 = 0; done1 = 0;
    end else begin
      if (done0) begin req0 = 1'b0; busy0 = 0; done0 = 0; end
      if (done1) begin req1 = 1'b0; busy1 = 0; done1 = 0; end
      if (!busy0 && q0.size() > 0) begin
        cur0 = q0.pop_front();
        req0 = 1'b1; we0 = cur0.we; addr0 = cur0.addr; wdata0 = cur0.data; busy0 = 1;
      end
      if (!busy1 && q1.size() > 0) begin
        cur1 = q1.pop_front();
        req1 = 1'b1; we1 = cur1.we; addr1 = cur1.addr; wdata1 = cur1.data; busy1 = 1;
      end
    end
    // Idle ports present junk to show the arbiter ignores it
    if (!req0) begin we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom; end
    if (!req1) begin we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom; end

    @(negedge clk);
    if (model_valid) begin
      exp_any = !rst_prev && (cyc - 1 >= free_at) && (req_prev != 2'b00);
      port    = (req_prev == 2'b11) ? 1 - last : (req_prev[1] ? 1 : 0);
      exp_gnt = exp_any ? (2'b01 << port) : 2'b00;
      check_eq("gnt", {gnt1, gnt0}, exp_gnt);
      c = (port == 1) ? cur1 : cur0;
      check_eq("ram_wr_sig", ram_wr_sig, exp_any && c.we);
      if (exp_any) begin
        check_eq("ram_addr", ram_addr, c.addr);
        if (c.we) begin
          check_eq("ram_wr_data", ram_wr_data, c.data);
          golden[c.addr[5:2]] = c.data;
          free_at = cyc + 1;
        end else begin
          rvq.push_back('{cyc: cyc + 1 + RD_LAT, port: port, data: golden[c.addr[5:2]]});
          free_at   = cyc + 2 + RD_LAT;
          hold_from = cyc + 1;
          hold_to   = cyc + RD_LAT;
          hold_addr = c.addr;
        end
        last = port;
        if (port == 1) done1 = 1; else done0 = 1;
      end
      if (cyc >= hold_from && cyc <= hold_to) check_eq("ram_addr_hold", ram_addr, hold_addr);
      if (rvq.size() > 0 && rvq[0].cyc == cyc) begin
        check_eq("rvalid", {rvalid1, rvalid0}, 2'b01 << rvq[0].port);
        check_eq("rdata", (rvq[0].port == 1) ? rdata1 : rdata0, rvq[0].data);
        void'(rvq.pop_front());
      end else begin
        check_eq("rvalid_idle", {rvalid1, rvalid0}, 2'b00);
      end
`ifdef MEM_ARB_STATS_EN
      check_eq("stat_conflicts", stat_conflicts, stat_model);
`else
      check_eq("stat_conflicts", stat_conflicts, 0);
`endif
      if (!reset && cyc >= free_at && req0 && req1 && stat_model < 65535) stat_model++;
    end
    if (reset) begin
      model_valid = 1;
      free_at     = cyc + 1;
      last        = 1;
      stat_model  = 0;
      hold_to     = -1;
      rvq.delete();
    end
    rst_prev = reset;
    req_prev = {req1, req0};
  endtask

  task automatic run_until_idle(input int budget);
    bit idle;
    idle = 0;
    for (int k = 0; k < budget; k++) begin
      idle = (q0.size() == 0) && (q1.size() == 0) && !busy0 && !busy1 &&
             (rvq.size() == 0) && (cyc >= free_at);
      if (idle) break;
      step();
    end
    check_eq("drain", {31'b0, !idle}, 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; free_at = 0; last = 1; stat_model = 0;
    hold_from = 0; hold_to = -1; hold_addr = '0;
    model_valid = 0; rst_prev = 1; req_prev = 2'b00;
    busy0 = 0; busy1 = 0; done0 = 0; done1 = 0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 16; i++) golden[i] = '0;

    rst_drive = 1;
    repeat (3) step();
    rst_drive = 0;
    step();
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_ram_wr_data", ram_wr_data, 0);
    check_eq("rst_rdata0", rdata0, 0);
    check_eq("rst_rdata1", rdata1, 0);

    // Write then read back on the CPU port
    q0.push_back(make_cmd(1'b1, 32'h10, 32'hDEADBEEF));
    q0.push_back(make_cmd(1'b0, 32'h10, 32'h0));
    run_until_idle(50);

    // Simultaneous reads straight after reset
    rst_drive = 1; step(); rst_drive = 0;
    q0.push_back(make_cmd(1'b0, 32'h10, 32'h0));
    q1.push_back(make_cmd(1'b0, 32'h20, 32'h0));
    run_until_idle(50);

    // Both ports streaming reads
    for (int i = 0; i < 8; i++) begin
      q0.push_back(make_cmd(1'b0, AW'($urandom_range(0, 15)) << 2, 32'h0));
      q1.push_back(make_cmd(1'b0, AW'($urandom_range(0, 15)) << 2, 32'h0));
    end
    run_until_idle(200);

    // Reset while a read sits in WAIT, then a fresh request
    q0.push_back(make_cmd(1'b0, 32'h10, 32'h0));
    for (int k = 0; k < 20 && !done0; k++) step();
    rst_drive = 1; step(); rst_drive = 0;
    q1.push_back(make_cmd(1'b0, 32'h10, 32'h0));
    run_until_idle(50);

    // Random mixed traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_cmd());
      if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_cmd());
      rst_drive = ($urandom_range(0, 399) == 0);
      step();
    end
    rst_drive = 0;
    run_until_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
